// File: rtl/rob_queue.sv
// ---------------------------------------------------------------------------
// rob_queue
// Reorder buffer built as a circular queue of ROB_DEPTH entries between
// decode and the register file. Each accepted dispatch is given a tag (the
// entry index at the tail). Results arrive on WB_PORTS writeback ports.
// Ready entries retire strictly in program order, at most one per cycle.
// A flush discards every entry in flight.
//
// Optional feature macro: ROB_WB_FORWARD_EN
//   defined   : a writeback that targets the head entry retires it at the
//               same edge, and the writeback value goes straight to
//               commit_value_o.
//   undefined : a writeback always lands in the entry first, so the entry
//               commits no earlier than the following edge.
//
// Ports
//   clk_i           clock, rising edge
//   rst_ni          asynchronous reset, active low
//   rdy_i           global enable; 0 freezes all state (commit pulse drops)
//   flush_i         mispredict; discards all entries, wins over everything
//   disp_valid_i    decode presents an instruction
//   disp_op_i       opcode of the dispatched instruction
//   disp_rd_i       destination register of the dispatched instruction
//   disp_pc_i       PC of the dispatched instruction
//   disp_ready_o    queue not full (combinational)
//   disp_tag_o      tag handed to a dispatch this cycle (tail pointer)
//   wb_valid_i      per-port writeback valid
//   wb_tag_i        per-port tag, port i at [i*TAG_W +: TAG_W]
//   wb_value_i      per-port result, port i at [i*DATA_W +: DATA_W]
//   commit_valid_o  one-cycle retire pulse
//   commit_op_o     retired opcode
//   commit_rd_o     retired destination register
//   commit_value_o  retired result
//   commit_pc_o     retired PC
//   commit_tag_o    retired tag
//   count_o         number of occupied entries, 0..ROB_DEPTH
// ---------------------------------------------------------------------------
module rob_queue #(
  parameter int ROB_DEPTH = 16,
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 5,
  parameter int OP_W      = 6,
  parameter int WB_PORTS  = 2,
  localparam int TAG_W    = $clog2(ROB_DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         rdy_i,
  input  logic                         flush_i,
  input  logic                         disp_valid_i,
  input  logic [OP_W-1:0]              disp_op_i,
  input  logic [REG_IDX_W-1:0]         disp_rd_i,
  input  logic [DATA_W-1:0]            disp_pc_i,
  output logic                         disp_ready_o,
  output logic [TAG_W-1:0]             disp_tag_o,
  input  logic [WB_PORTS-1:0]          wb_valid_i,
  input  logic [WB_PORTS*TAG_W-1:0]    wb_tag_i,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_value_i,
  output logic                         commit_valid_o,
  output logic [OP_W-1:0]              commit_op_o,
  output logic [REG_IDX_W-1:0]         commit_rd_o,
  output logic [DATA_W-1:0]            commit_value_o,
  output logic [DATA_W-1:0]            commit_pc_o,
  output logic [TAG_W-1:0]             commit_tag_o,
  output logic [TAG_W:0]               count_o
);

  localparam logic [TAG_W:0] FullCount = (TAG_W+1)'(ROB_DEPTH);

  // Queue pointers and occupancy
  logic [TAG_W-1:0]     head_q, tail_q;
  logic [TAG_W:0]       count_q, count_d;

  // Per-entry state and payload
  logic [ROB_DEPTH-1:0] busy_q, ready_q;
  logic [OP_W-1:0]      op_q    [ROB_DEPTH];
  logic [REG_IDX_W-1:0] rd_q    [ROB_DEPTH];
  logic [DATA_W-1:0]    pc_q    [ROB_DEPTH];
  logic [DATA_W-1:0]    value_q [ROB_DEPTH];

  // Registered commit outputs
  logic                 commit_valid_q;
  logic [OP_W-1:0]      commit_op_q;
  logic [REG_IDX_W-1:0] commit_rd_q;
  logic [DATA_W-1:0]    commit_value_q;
  logic [DATA_W-1:0]    commit_pc_q;
  logic [TAG_W-1:0]     commit_tag_q;

  // Writeback decoded per entry
  logic [ROB_DEPTH-1:0] wb_en;
  logic [DATA_W-1:0]    wb_val [ROB_DEPTH];

  logic                 do_disp;
  logic                 do_commit;
  logic                 head_done;
  logic [DATA_W-1:0]    head_value;

  assign disp_ready_o   = (count_q != FullCount);
  assign disp_tag_o     = tail_q;
  assign count_o        = count_q;
  assign commit_valid_o = commit_valid_q;
  assign commit_op_o    = commit_op_q;
  assign commit_rd_o    = commit_rd_q;
  assign commit_value_o = commit_value_q;
  assign commit_pc_o    = commit_pc_q;
  assign commit_tag_o   = commit_tag_q;

  // Ports are scanned in ascending order so that, when two ports name the
  // same tag, the higher-indexed port overwrites the lower one.
  // Writebacks to entries that are not busy are dropped here.
  always_comb begin
    wb_en = '0;
    for (int e = 0; e < ROB_DEPTH; e++) begin
      wb_val[e] = '0;
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid_i[p] && busy_q[wb_tag_i[p*TAG_W +: TAG_W]]) begin
        wb_en[wb_tag_i[p*TAG_W +: TAG_W]]  = 1'b1;
        wb_val[wb_tag_i[p*TAG_W +: TAG_W]] = wb_value_i[p*DATA_W +: DATA_W];
      end
    end
  end

`ifdef ROB_WB_FORWARD_EN
  // A result arriving for the head this cycle lets it retire immediately.
  assign head_done  = ready_q[head_q] | wb_en[head_q];
  assign head_value = wb_en[head_q] ? wb_val[head_q] : value_q[head_q];
`else
  assign head_done  = ready_q[head_q];
  assign head_value = value_q[head_q];
`endif

  // Dispatch is blocked whenever the queue is full at the edge, even if the
  // head retires in the same cycle, so the slot being freed is never reused
  // in that cycle.
  assign do_disp   = disp_valid_i & disp_ready_o;
  assign do_commit = (count_q != '0) & head_done;
  assign count_d   = count_q + {{TAG_W{1'b0}}, do_disp} - {{TAG_W{1'b0}}, do_commit};

  // Within one enabled edge the order below matters: writeback first, then
  // the head is cleared on commit, then the tail entry is written. Head and
  // tail only coincide when the queue is full or empty, and in both cases
  // at most one of commit/dispatch can fire.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      ready_q        <= '0;
      for (int e = 0; e < ROB_DEPTH; e++) begin
        op_q[e]    <= '0;
        rd_q[e]    <= '0;
        pc_q[e]    <= '0;
        value_q[e] <= '0;
      end
      commit_valid_q <= 1'b0;
      commit_op_q    <= '0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_pc_q    <= '0;
      commit_tag_q   <= '0;
    end else if (!rdy_i) begin
      commit_valid_q <= 1'b0;
    end else if (flush_i) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      ready_q        <= '0;
      commit_valid_q <= 1'b0;
    end else begin
      for (int e = 0; e < ROB_DEPTH; e++) begin
        if (wb_en[e]) begin
          value_q[e] <= wb_val[e];
          ready_q[e] <= 1'b1;
        end
      end

      if (do_commit) begin
        commit_valid_q  <= 1'b1;
        commit_op_q     <= op_q[head_q];
        commit_rd_q     <= rd_q[head_q];
        commit_value_q  <= head_value;
        commit_pc_q     <= pc_q[head_q];
        commit_tag_q    <= head_q;
        busy_q[head_q]  <= 1'b0;
        ready_q[head_q] <= 1'b0;
        head_q          <= head_q + TAG_W'(1);
      end else begin
        commit_valid_q  <= 1'b0;
      end

      if (do_disp) begin
        op_q[tail_q]    <= disp_op_i;
        rd_q[tail_q]    <= disp_rd_i;
        pc_q[tail_q]    <= disp_pc_i;
        busy_q[tail_q]  <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        tail_q          <= tail_q + TAG_W'(1);
      end

      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_rob_queue.sv
// ---------------------------------------------------------------------------
// tb_rob_queue
// Directed bench for rob_queue with default parameters. Every accepted
// dispatch is pushed to a program-order scoreboard; writeback values are
// recorded per tag; each observed commit pulse pops the scoreboard and is
// compared field by field. Directed checks cover occupancy, back-pressure,
// pointer wrap, port priority, flush, async reset, freeze and latency.
// ---------------------------------------------------------------------------
module tb_rob_queue;

  localparam int Depth = 16;

`ifdef ROB_WB_FORWARD_EN
  localparam logic Fwd = 1'b1;
`else
  localparam logic Fwd = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        rdy = 1'b0;
  logic        flush = 1'b0;
  logic        dispValid = 1'b0;
  logic [5:0]  dispOp = '0;
  logic [4:0]  dispRd = '0;
  logic [31:0] dispPc = '0;
  logic [1:0]  wbValid = '0;
  logic [7:0]  wbTag = '0;
  logic [63:0] wbValue = '0;

  logic        dispReady;
  logic [3:0]  dispTag;
  logic        commitValid;
  logic [5:0]  commitOp;
  logic [4:0]  commitRd;
  logic [31:0] commitValue;
  logic [31:0] commitPc;
  logic [3:0]  commitTag;
  logic [4:0]  count;

  rob_queue dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .rdy_i          (rdy),
    .flush_i        (flush),
    .disp_valid_i   (dispValid),
    .disp_op_i      (dispOp),
    .disp_rd_i      (dispRd),
    .disp_pc_i      (dispPc),
    .disp_ready_o   (dispReady),
    .disp_tag_o     (dispTag),
    .wb_valid_i     (wbValid),
    .wb_tag_i       (wbTag),
    .wb_value_i     (wbValue),
    .commit_valid_o (commitValid),
    .commit_op_o    (commitOp),
    .commit_rd_o    (commitRd),
    .commit_value_o (commitValue),
    .commit_pc_o    (commitPc),
    .commit_tag_o   (commitTag),
    .count_o        (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  tag;
    logic [4:0]  rd;
    logic [5:0]  op;
    logic [31:0] pc;
  } sbEntry_t;

  sbEntry_t        sbQ[$];
  logic [31:0]     mdlVal [Depth];
  logic [Depth-1:0] mdlBusy = '0;
  int              mdlCount = 0;
  logic [3:0]      mdlTail = '0;
  int              commitsSeen = 0;
  int              testsRun = 0;
  int              testsFailed = 0;

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  task automatic clearModel();
    sbQ.delete();
    mdlBusy  = '0;
    mdlCount = 0;
    mdlTail  = '0;
  endtask

  // Pops one scoreboard entry for every commit pulse seen.
  task automatic sampleCommit();
    sbEntry_t e;
    if (commitValid === 1'b1) begin
      testsRun++;
      assert (sbQ.size() != 0) else begin
        testsFailed++;
        $error("[TB] FAIL unexpected_commit observed tag=%0d expected no commit", commitTag);
      end
      if (sbQ.size() != 0) begin
        e = sbQ.pop_front();
        checkOutput("commit_tag",   commitTag,   e.tag);
        checkOutput("commit_rd",    commitRd,    e.rd);
        checkOutput("commit_op",    commitOp,    e.op);
        checkOutput("commit_pc",    commitPc,    e.pc);
        checkOutput("commit_value", commitValue, mdlVal[e.tag]);
        mdlBusy[e.tag] = 1'b0;
        mdlCount--;
        commitsSeen++;
      end
    end
  endtask

  // One clock step: drive all inputs, update the bench's expectations,
  // take the edge, then sample 1 time unit later.
  task automatic applyStimulus(input logic en, input logic fl, input logic dv,
                               input logic [5:0] op, input logic [4:0] rd,
                               input logic [31:0] pc, input logic [1:0] wv,
                               input logic [3:0] t0, input logic [31:0] v0,
                               input logic [3:0] t1, input logic [31:0] v1);
    sbEntry_t e;
    rdy       = en;
    flush     = fl;
    dispValid = dv;
    dispOp    = op;
    dispRd    = rd;
    dispPc    = pc;
    wbValid   = wv;
    wbTag     = {t1, t0};
    wbValue   = {v1, v0};
    #1;
    if (dv) begin
      checkOutput("disp_ready", dispReady, (mdlCount < Depth));
      if (mdlCount < Depth) checkOutput("disp_tag", dispTag, mdlTail);
    end
    if (en && fl) begin
      clearModel();
    end else if (en) begin
      if (wv[0] && mdlBusy[t0]) mdlVal[t0] = v0;
      if (wv[1] && mdlBusy[t1]) mdlVal[t1] = v1;
      if (dv && mdlCount < Depth) begin
        e.tag = mdlTail;
        e.rd  = rd;
        e.op  = op;
        e.pc  = pc;
        sbQ.push_back(e);
        mdlBusy[mdlTail] = 1'b1;
        mdlVal[mdlTail]  = '0;
        mdlTail++;
        mdlCount++;
      end
    end
    @(posedge clk);
    #1;
    sampleCommit();
  endtask

  task automatic dispatch(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] pc);
    applyStimulus(1'b1, 1'b0, 1'b1, op, rd, pc, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
  endtask

  task automatic writeback(input logic [1:0] wv, input logic [3:0] t0, input logic [31:0] v0,
                           input logic [3:0] t1, input logic [31:0] v1);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 5'd0, 32'd0, wv, t0, v0, t1, v1);
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 5'd0, 32'd0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
  endtask

  task automatic applyReset();
    rstN      = 1'b0;
    rdy       = 1'b0;
    flush     = 1'b0;
    dispValid = 1'b0;
    wbValid   = '0;
    repeat (2) @(posedge clk);
    #1;
    clearModel();
    rstN = 1'b1;
  endtask

  initial begin
    int         startCommits;
    logic [3:0] t;

    // Reset state
    applyReset();
    checkOutput("rst_count",        count,       5'd0);
    checkOutput("rst_disp_ready",   dispReady,   1'b1);
    checkOutput("rst_disp_tag",     dispTag,     4'd0);
    checkOutput("rst_commit_valid", commitValid, 1'b0);
    checkOutput("rst_commit_value", commitValue, 32'd0);
    checkOutput("rst_commit_pc",    commitPc,    32'd0);

    // In-order retirement from out-of-order writebacks
    startCommits = commitsSeen;
    dispatch(6'd1, 5'd1, 32'h100);
    dispatch(6'd2, 5'd2, 32'h104);
    dispatch(6'd3, 5'd3, 32'h108);
    checkOutput("t1_count3", count, 5'd3);
    writeback(2'b01, 4'd2, 32'h30, 4'd0, 32'd0);
    writeback(2'b01, 4'd0, 32'h10, 4'd0, 32'd0);
    writeback(2'b01, 4'd1, 32'h20, 4'd0, 32'd0);
    repeat (3) idle();
    checkOutput("t1_commits", commitsSeen - startCommits, 3);
    checkOutput("t1_count0",  count, 5'd0);

    // Writeback-to-commit latency on the head
    t = mdlTail;
    dispatch(6'd9, 5'd9, 32'h900);
    writeback(2'b01, t, 32'h66, 4'd0, 32'd0);
    checkOutput("t6_valid_edgeN",  commitValid, Fwd);
    idle();
    checkOutput("t6_valid_edgeN1", commitValid, !Fwd);
    checkOutput("t6_count0",       count, 5'd0);

    // Fill to full, blocked dispatch, wrap of the tail
    applyReset();
    for (int i = 0; i < Depth; i++) begin
      dispatch(6'(i), 5'(i), 32'h200 + 32'(4*i));
    end
    checkOutput("t2_count_full",  count,     5'd16);
    checkOutput("t2_ready_full",  dispReady, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'h3F, 5'd31, 32'hBAD0,
                  2'b01, 4'd0, 32'h55, 4'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, !Fwd, 6'h3E, 5'd30, 32'hBAD4,
                  2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    checkOutput("t2_count_after", count,     5'd15);
    checkOutput("t2_ready_after", dispReady, 1'b1);
    checkOutput("t2_tag_wrap",    dispTag,   4'd0);

    // Two ports on the same tag, then a writeback to a free tag
    writeback(2'b11, 4'd1, 32'hA, 4'd1, 32'hB);
    idle();
    idle();
    checkOutput("t3_count",        count, 5'd14);
    writeback(2'b01, 4'd0, 32'hDEAD, 4'd0, 32'd0);
    checkOutput("t3_free_count",   count,       5'd14);
    checkOutput("t3_free_valid",   commitValid, 1'b0);
    idle();
    checkOutput("t3_free_valid2",  commitValid, 1'b0);
    checkOutput("t3_free_count2",  count,       5'd14);

    // Flush with simultaneous dispatch and writeback
    applyReset();
    for (int i = 0; i < 5; i++) begin
      dispatch(6'd4, 5'(i + 10), 32'h400 + 32'(4*i));
    end
    writeback(2'b01, 4'd0, 32'h40, 4'd0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 6'd5, 5'd20, 32'h480,
                  2'b01, 4'd1, 32'h41, 4'd0, 32'd0);
    checkOutput("t4_count",       count,       5'd0);
    checkOutput("t4_valid",       commitValid, 1'b0);
    checkOutput("t4_disp_ready",  dispReady,   1'b1);
    checkOutput("t4_disp_tag",    dispTag,     4'd0);
    idle();
    checkOutput("t4_valid2",      commitValid, 1'b0);
    dispatch(6'd7, 5'd7, 32'h700);
    writeback(2'b01, 4'd0, 32'h70, 4'd0, 32'd0);
    idle();
    idle();
    checkOutput("t4_count_end",   count, 5'd0);

    // Asynchronous reset in the middle of a cycle
    for (int i = 0; i < 8; i++) begin
      dispatch(6'd8, 5'(i + 1), 32'h800 + 32'(4*i));
    end
    writeback(2'b01, 4'd1, 32'h77, 4'd0, 32'd0);
    idle();
    checkOutput("t5_pre_value", commitValue, 32'h77);
    checkOutput("t5_pre_count", count,       5'd7);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t5_async_count",   count,       5'd0);
    checkOutput("t5_async_valid",   commitValid, 1'b0);
    checkOutput("t5_async_value",   commitValue, 32'd0);
    checkOutput("t5_async_pc",      commitPc,    32'd0);
    checkOutput("t5_async_tag",     commitTag,   4'd0);
    checkOutput("t5_async_ready",   dispReady,   1'b1);
    checkOutput("t5_async_disptag", dispTag,     4'd0);
    clearModel();
    @(posedge clk);
    #1;
    rstN = 1'b1;

    // Freeze with a ready head
    dispatch(6'd10, 5'd10, 32'hA00);
    dispatch(6'd11, 5'd11, 32'hA04);
    writeback(2'b01, 4'd1, 32'h61, 4'd0, 32'd0);
    writeback(2'b01, 4'd0, 32'h60, 4'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 5'd0, 32'd0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
      checkOutput("t5_frozen_valid", commitValid, 1'b0);
    end
    idle();
    checkOutput("t5_thaw_valid", commitValid, 1'b1);
    idle();
    idle();
    checkOutput("t5_count_end", count, 5'd0);

    testsRun++;
    assert (sbQ.size() == 0) else begin
      testsFailed++;
      $error("[TB] FAIL sb_drained observed=%0d entries expected=0", sbQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
